// File: rtl/mccpu_if.sv
// mccpu_if: memory request/response bus between the core (master) and memory (slave).
interface mccpu_if;
    localparam int unsigned XLEN = 32;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mccpu.sv
// mccpu: multi-cycle MIPS-subset core (IF/ID/EX/MEM/WB/HALT) on a single
// request/ready memory bus, with a combinational debug register read port.
// Optional: define MCCPU_PERF_CNT_EN to add cyc_cnt and instret_cnt outputs.
module mccpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned MEM_AW   = 32
) (
    input  logic        clk,
    input  logic        rst,
    mccpu_if.master     bus,
    output logic [31:0] pc,
    output logic        halted,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
`ifdef MCCPU_PERF_CNT_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] instret_cnt
`endif
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ADDR_MASK = (MEM_AW >= XLEN) ? {XLEN{1'b1}}
                                          : XLEN'((64'd1 << MEM_AW) - 64'd1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
    logic            halted_q;
    logic [XLEN-1:0] rf [32];

    logic            mem_req_c, mem_we_c;
    logic [XLEN-1:0] mem_addr_c, alu_c;

    // Instruction fields
    logic [5:0]      opcode, funct;
    logic [4:0]      rs, rt, rd, shamt, dest;
    logic [15:0]     imm16;
    logic [25:0]     imm26;
    logic [XLEN-1:0] imm_sext, imm_zext;
    logic            is_rtype, is_lw, is_sw, is_beq, is_j, legal;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm16    = ir_q[15:0];
    assign imm26    = ir_q[25:0];
    assign imm_sext = {{16{imm16[15]}}, imm16};
    assign imm_zext = {16'h0000, imm16};

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign dest     = is_rtype ? rd : rt;

    // Legal opcode/funct decode
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                    default:                                        legal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // ALU result for the EX stage; lw/sw addresses are forced word-aligned here
    always_comb begin
        alu_c = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_c = a_q + b_q;
                    FN_SUB:  alu_c = a_q - b_q;
                    FN_AND:  alu_c = a_q & b_q;
                    FN_OR:   alu_c = a_q | b_q;
                    FN_SLT:  alu_c = {31'b0, ($signed(a_q) < $signed(b_q))};
                    FN_SLL:  alu_c = b_q << shamt;
                    default: alu_c = '0;
                endcase
            end
            OP_ADDI:      alu_c = a_q + imm_sext;
            OP_ORI:       alu_c = a_q | imm_zext;
            OP_LUI:       alu_c = {imm16, 16'h0000};
            OP_LW, OP_SW: alu_c = (a_q + imm_sext) & ~32'h3;
            default:      alu_c = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and bus request outputs
    always_comb begin
        state_d    = state_q;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        mem_addr_c = pc_q;
        case (state_q)
            S_IF: begin
                mem_req_c = 1'b1;
                if (bus.mem_ready) state_d = S_ID;
            end
            S_ID: state_d = legal ? S_EX : S_HALT;
            S_EX: begin
                if (is_lw || is_sw)      state_d = S_MEM;
                else if (is_beq || is_j) state_d = S_IF;
                else                     state_d = S_WB;
            end
            S_MEM: begin
                mem_req_c  = 1'b1;
                mem_we_c   = is_sw;
                mem_addr_c = alu_q;
                if (bus.mem_ready) state_d = is_sw ? S_IF : S_WB;
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Requests are suppressed while reset is asserted so a pending transfer is dropped
    assign bus.mem_req   = mem_req_c & ~rst;
    assign bus.mem_we    = mem_we_c & ~rst;
    assign bus.mem_addr  = mem_addr_c & ADDR_MASK & ~32'h3;
    assign bus.mem_wdata = b_q;

    // Datapath registers: PC, IR, operand latches, ALU and memory data
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IF: begin
                    if (bus.mem_ready) begin
                        ir_q <= bus.mem_rdata;
                        pc_q <= pc_q + 32'd4;
                    end
                end
                S_ID: begin
                    a_q <= rf[rs];
                    b_q <= rf[rt];
                    if (!legal) halted_q <= 1'b1;
                end
                S_EX: begin
                    alu_q <= alu_c;
                    if (is_beq && (a_q == b_q)) begin
                        pc_q <= pc_q + {imm_sext[29:0], 2'b00};
                    end else if (is_j) begin
                        pc_q <= {pc_q[31:28], imm26, 2'b00};
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready && is_lw) mdr_q <= bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Register file write-back; $0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if ((state_q == S_WB) && (dest != 5'd0)) begin
            rf[dest] <= is_lw ? mdr_q : alu_q;
        end
    end

    assign reg_data = (reg_sel == 5'd0) ? '0 : rf[reg_sel];
    assign pc       = pc_q;
    assign halted   = halted_q;

`ifdef MCCPU_PERF_CNT_EN
    logic [XLEN-1:0] cyc_q, instret_q;

    // Cycle and retired-instruction counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q     <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_HALT) cyc_q <= cyc_q + 32'd1;
            if ((state_d == S_IF) && (state_q != S_IF)) instret_q <= instret_q + 32'd1;
        end
    end

    assign cyc_cnt     = cyc_q;
    assign instret_cnt = instret_q;
`endif
endmodule

// File: tb/tb_mccpu.sv
// tb_mccpu: randomized and directed checks of mccpu against an instruction-level model.
module tb_mccpu;
    localparam int unsigned MEM_WORDS = 4096;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  reg_sel = 5'd0;
    logic [31:0] pc, reg_data;
    logic        halted;
`ifdef MCCPU_PERF_CNT_EN
    logic [31:0] cyc_cnt, instret_cnt;
`endif

    mccpu_if bus ();

    mccpu #(.RESET_PC(RESET_PC), .MEM_AW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .pc       (pc),
        .halted   (halted),
        .reg_sel  (reg_sel),
        .reg_data (reg_data)
`ifdef MCCPU_PERF_CNT_EN
        ,
        .cyc_cnt     (cyc_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory image seen by the DUT, and the model's architectural state
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] ref_regs[32];
    logic [31:0] ref_pc;

    int          checks = 0;
    int          errors = 0;
    int          cycles;
    int          wait_mode;
    int          wait_cnt;
    int          we_cycles;
    logic [31:0] last_wdata;
    bit          prev_stall;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
    endtask

    task automatic load(input int unsigned k, input logic [31:0] word);
        logic [31:0] a;
        a = RESET_PC + 32'(k * 4);
        mem[a[13:2]]     = word;
        ref_mem[a[13:2]] = word;
    endtask

    // One clock of memory slave behaviour: bus stability, ready policy, data, stores
    task automatic tick(output bit stalled);
        logic        rdy;
        logic [11:0] idx;
        idx = bus.mem_addr[13:2];
        if (prev_stall && !rst) begin
            check("hold_addr", bus.mem_addr, prev_addr);
            check("hold_we", 32'(bus.mem_we), 32'(prev_we));
            check("hold_wdata", bus.mem_wdata, prev_wdata);
        end
        case (wait_mode)
            0:       rdy = 1'b1;
            1:       rdy = (wait_cnt >= 3);
            default: rdy = ($urandom_range(0, 2) != 0);
        endcase
        if (bus.mem_req) begin
            if (rdy) wait_cnt = 0;
            else     wait_cnt++;
        end
        bus.mem_ready = rdy;
        bus.mem_rdata = mem[idx];
        if (bus.mem_req && bus.mem_we) begin
            we_cycles++;
            last_wdata = bus.mem_wdata;
            if (rdy) mem[idx] = bus.mem_wdata;
        end
        stalled    = bus.mem_req && !rdy;
        prev_stall = stalled;
        prev_addr  = bus.mem_addr;
        prev_we    = bus.mem_we;
        prev_wdata = bus.mem_wdata;
        if (!rst) cycles++;
        @(posedge clk);
        #1;
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
        prev_stall = 1'b0;
    endtask

    task automatic ref_wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) ref_regs[r] = v;
    endtask

    // Instruction-level model: executes one instruction, reports ideal cycle count
    task automatic ref_step(output int cyc, output bit ill);
        logic [31:0] ir, a, b, se, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        ir = ref_mem[ref_pc[13:2]];
        ref_pc = ref_pc + 32'd4;
        op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16];
        rd = ir[15:11]; sh = ir[10:6];  fn = ir[5:0];
        a  = ref_regs[rs];
        b  = ref_regs[rt];
        se = {{16{ir[15]}}, ir[15:0]};
        ea = (a + se) & ~32'h3;
        ill = 1'b0;
        cyc = 4;
        case (op)
            6'd0: begin
                case (fn)
                    6'd32:   ref_wr(rd, a + b);
                    6'd34:   ref_wr(rd, a - b);
                    6'd36:   ref_wr(rd, a & b);
                    6'd37:   ref_wr(rd, a | b);
                    6'd42:   ref_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    6'd0:    ref_wr(rd, b << sh);
                    default: ill = 1'b1;
                endcase
            end
            6'd8:  ref_wr(rt, a + se);
            6'd13: ref_wr(rt, a | {16'h0, ir[15:0]});
            6'd15: ref_wr(rt, {ir[15:0], 16'h0});
            6'd35: begin ref_wr(rt, ref_mem[ea[13:2]]); cyc = 5; end
            6'd43: ref_mem[ea[13:2]] = b;
            6'd4:  begin if (a == b) ref_pc = ref_pc + (se << 2); cyc = 3; end
            6'd2:  begin ref_pc = {ref_pc[31:28], ir[25:0], 2'b00}; cyc = 3; end
            default: ill = 1'b1;
        endcase
        if (ill) cyc = 2;
    endtask

    // Run the DUT for one instruction (stall cycles extend the ideal count)
    task automatic run_instr();
        int cyc, n, guard;
        bit ill, st;
        check("fetch_req", 32'(bus.mem_req), 32'd1);
        check("fetch_we", 32'(bus.mem_we), 32'd0);
        check("fetch_addr", bus.mem_addr, ref_pc);
        ref_step(cyc, ill);
        n = 0;
        guard = 0;
        while (n < cyc && guard < 200) begin
            tick(st);
            if (!st) n++;
            guard++;
        end
        check("instr_budget", 32'(n), 32'(cyc));
        check("pc", pc, ref_pc);
        check("halted", 32'(halted), 32'(ill));
    endtask

    task automatic do_reset();
        bit st;
        rst = 1'b1;
        #1;
        wait_cnt   = 0;
        prev_stall = 1'b0;
        tick(st);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        tick(st);
        rst = 1'b0;
        #1;
        cycles = 0;
        ref_pc = RESET_PC;
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        check("rst_pc", pc, RESET_PC);
        check("rst_halted", 32'(halted), 32'd0);
    endtask

    // Register reads while the core is held in a stalled fetch
    task automatic peek(input int r, input logic [31:0] exp, input string tag);
        bus.mem_ready = 1'b0;
        reg_sel = 5'(r);
        #1;
        check(tag, reg_data, exp);
        resync();
    endtask

    task automatic check_regs(input string tag);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            reg_sel = 5'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), reg_data, ref_regs[i]);
        end
        resync();
    endtask

    task automatic gen_program(input int unsigned n);
        logic [4:0]  rs, rt, rd;
        logic [31:0] w;
        for (int unsigned k = 0; k < n; k++) begin
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 11))
                0:  w = enc_r(rs, rt, rd, 5'd0, 6'h20);
                1:  w = enc_r(rs, rt, rd, 5'd0, 6'h22);
                2:  w = enc_r(rs, rt, rd, 5'd0, 6'h24);
                3:  w = enc_r(rs, rt, rd, 5'd0, 6'h25);
                4:  w = enc_r(rs, rt, rd, 5'd0, 6'h2A);
                5:  w = enc_r(5'd0, rt, rd, 5'($urandom_range(0, 31)), 6'h00);
                6:  w = enc_i(6'h08, rs, rt, 16'($urandom));
                7:  w = enc_i(6'h0D, rs, rt, 16'($urandom));
                8:  w = enc_i(6'h0F, 5'd0, rt, 16'($urandom));
                9:  w = enc_i(6'h23, 5'd0, rt, 16'($urandom_range(0, 63)));
                10: w = enc_i(6'h2B, 5'd0, rt, 16'($urandom_range(0, 63)));
                default: w = enc_i(6'h04, rs, rt, 16'($urandom_range(0, 2)));
            endcase
            load(k, w);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit st;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        wait_mode  = 0;
        wait_cnt   = 0;
        we_cycles  = 0;
        cycles     = 0;
        last_wdata = '0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;

        // ALU program, then store/load with three wait states per request
        clear_mem();
        load(0, 32'h2001_FFFF);
        load(1, 32'h3402_FFFF);
        load(2, 32'h0022_182A);
        load(3, 32'h3C04_1234);
        load(4, 32'hAC02_0004);
        load(5, 32'h8C05_0004);
        do_reset();
        check("first_fetch_addr", bus.mem_addr, 32'h0000_3000);
        repeat (4) run_instr();
        check("alu_cycles", 32'(cycles), 32'd16);
`ifdef MCCPU_PERF_CNT_EN
        check("perf_instret", instret_cnt, 32'd4);
        check("perf_cyc", cyc_cnt, 32'd16);
`endif
        peek(1, 32'hFFFF_FFFF, "addi_r1");
        peek(2, 32'h0000_FFFF, "ori_r2");
        peek(3, 32'h0000_0001, "slt_r3");
        peek(4, 32'h1234_0000, "lui_r4");
        wait_mode = 1;
        we_cycles = 0;
        run_instr();
        check("sw_wdata", last_wdata, 32'h0000_FFFF);
        check("sw_hold_cycles", 32'(we_cycles), 32'd4);
        check("sw_mem", mem[1], 32'h0000_FFFF);
        run_instr();
        peek(5, 32'h0000_FFFF, "lw_r5");
        check_regs("ldst");

        // Backward branch onto itself, then a jump
        wait_mode = 0;
        clear_mem();
        load(4, 32'h1000_FFFF);
        do_reset();
        repeat (5) run_instr();
        check("beq_pc", pc, 32'h0000_3010);
        run_instr();
        check("beq_pc2", pc, 32'h0000_3010);
        clear_mem();
        load(0, 32'h08C0_1000);
        do_reset();
        run_instr();
        check("j_pc", pc, 32'h0300_4000);
        check("j_fetch", bus.mem_addr, 32'h0300_4000);

        // Reset during a stalled fetch, then $0 write and illegal opcode
        clear_mem();
        load(0, 32'h2000_0005);
        load(1, 32'hFC00_0000);
        do_reset();
        wait_mode = 1;
        tick(st);
        tick(st);
        do_reset();
        check("abandon_req", 32'(bus.mem_req), 32'd1);
        check("abandon_addr", bus.mem_addr, RESET_PC);
        wait_mode = 2;
        run_instr();
        peek(0, 32'h0, "zero_reg");
        run_instr();
        check("halt_pc", pc, 32'h0000_3008);
        for (int i = 0; i < 6; i++) begin
            tick(st);
            check("halt_req", 32'(bus.mem_req), 32'd0);
            check("halt_hold_pc", pc, 32'h0000_3008);
            check("halt_flag", 32'(halted), 32'd1);
        end
        check_regs("halt");

        // Random straight-line programs with forward branches and random stalls
        for (int r = 0; r < 3; r++) begin
            clear_mem();
            gen_program(24);
            do_reset();
            wait_mode = 2;
            repeat (40) run_instr();
            check_regs($sformatf("rand%0d", r));
            for (int w = 0; w < 16; w++) begin
                check($sformatf("rand%0d_mem%0d", r, w), mem[w], ref_mem[w]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
